// File: rtl/fft_src_pkg.sv
// Shared types and defaults for the FFT frame source.
package fft_src_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CFG  = 2'd1,
    S_SEND = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  localparam int DATA_W_DEF        = 64;
  localparam int CONFIG_W_DEF      = 8;
  localparam int FRAME_LEN_MAX_DEF = 1024;
  localparam int GAP_W_DEF         = 8;

  // Real part of a packed complex sample (low half).
  function automatic logic [31:0] sample_re(input logic [63:0] s);
    return s[31:0];
  endfunction

  // Imaginary part of a packed complex sample (high half).
  function automatic logic [31:0] sample_im(input logic [63:0] s);
    return s[63:32];
  endfunction

endpackage

// File: rtl/fft_sample_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
module fft_sample_ram #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port and 1-cycle-latency read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_source.sv
// AXI-Stream frame source: config beat, then frames read from the sample RAM.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a start with a legal frame length
// CFG   | presenting the latched config word on the config channel
// SEND  | streaming samples 0..frame_len-1, tlast on the final beat
// GAP   | gap_cycles+1 idle cycles between frames
module fft_frame_source
  import fft_src_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int FRAME_LEN_MAX = FRAME_LEN_MAX_DEF,
  parameter int CONFIG_W      = CONFIG_W_DEF,
  parameter int GAP_W         = GAP_W_DEF,
  parameter int ADDR_W        = $clog2(FRAME_LEN_MAX)
) (
  input  logic                aclk,
  input  logic                areset,
  input  logic                ld_wr_en,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic [ADDR_W:0]     frame_len,
  input  logic [GAP_W-1:0]    gap_cycles,
  input  logic [15:0]         num_frames,
  input  logic                cfg_each_frame,
  input  logic [CONFIG_W-1:0] cfg_word,
  input  logic                start,
  input  logic                stop,
  output logic [CONFIG_W-1:0] m_axis_config_tdata,
  output logic                m_axis_config_tvalid,
  input  logic                m_axis_config_tready,
  output logic [DATA_W-1:0]   m_axis_data_tdata,
  output logic                m_axis_data_tvalid,
  output logic                m_axis_data_tlast,
  input  logic                m_axis_data_tready,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [15:0]         frames_sent
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(FRAME_LEN_MAX);
  localparam logic [ADDR_W:0] ONE     = (ADDR_W+1)'(1);

  state_t              state, state_nxt;
  logic [ADDR_W:0]     len_q;
  logic [GAP_W-1:0]    gap_q, gap_cnt;
  logic [15:0]         nfr_q;
  logic                each_q;
  logic [CONFIG_W-1:0] cfg_q;
  logic                stop_q;

  logic [ADDR_W:0]     rd_cnt;
  logic                rd_en, rd_pend, rd_pend_last;
  logic [DATA_W-1:0]   rd_data;

  // Two-entry skid buffer between the RAM read port and the data channel.
  logic [DATA_W-1:0]   sk_data [2];
  logic                sk_last [2];
  logic                sk_wp, sk_rp;
  logic [1:0]          sk_cnt;
  logic [2:0]          occ;

  logic                start_ok, cfg_hs, pop, last_hs, stop_eff, target_hit, done_set;
  logic [15:0]         frames_inc;

  assign start_ok   = start && (frame_len != '0) && (frame_len <= LEN_MAX);
  assign cfg_hs     = m_axis_config_tvalid && m_axis_config_tready;
  assign pop        = m_axis_data_tvalid && m_axis_data_tready;
  assign last_hs    = pop && m_axis_data_tlast;
  assign stop_eff   = stop_q || stop;
  assign frames_inc = (frames_sent == 16'hFFFF) ? frames_sent : frames_sent + 16'd1;
  assign target_hit = (nfr_q != 16'd0) && (frames_inc == nfr_q);

  assign m_axis_config_tdata = cfg_q;
  assign m_axis_data_tvalid  = (sk_cnt != 2'd0);
  assign m_axis_data_tdata   = sk_data[sk_rp];
  assign m_axis_data_tlast   = sk_last[sk_rp];

  // Reads in flight plus buffered beats must never exceed the two skid slots;
  // the first read is issued on the edge that enters SEND so data follows
  // the config handshake after exactly one RAM cycle.
  assign occ   = 3'(sk_cnt) + 3'(rd_pend) - 3'(pop);
  assign rd_en = (state_nxt == S_SEND) && (rd_cnt < len_q) && (occ < 3'd2);

  fft_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (FRAME_LEN_MAX),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (aclk),
    .wr_en   (ld_wr_en),
    .wr_addr (ld_addr),
    .wr_data (ld_data),
    .rd_en   (rd_en),
    .rd_addr (rd_cnt[ADDR_W-1:0]),
    .rd_data (rd_data)
  );

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode and state-derived outputs.
  always_comb begin
    state_nxt            = state;
    m_axis_config_tvalid = 1'b0;
    busy                 = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = S_CFG;
      end
      S_CFG: begin
        m_axis_config_tvalid = 1'b1;
        if (cfg_hs) state_nxt = stop_eff ? S_IDLE : S_SEND;
      end
      S_SEND: begin
        if (last_hs) state_nxt = (target_hit || stop_eff) ? S_IDLE : S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = stop_eff ? S_IDLE : (each_q ? S_CFG : S_SEND);
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign done_set = (state != S_IDLE) && (state_nxt == S_IDLE);

  // Latched parameters, counters, status pulses and the read/skid pipeline.
  always_ff @(posedge aclk) begin
    if (areset) begin
      len_q        <= '0;
      gap_q        <= '0;
      nfr_q        <= '0;
      each_q       <= 1'b0;
      cfg_q        <= '0;
      stop_q       <= 1'b0;
      gap_cnt      <= '0;
      frames_sent  <= '0;
      done         <= 1'b0;
      err          <= 1'b0;
      rd_cnt       <= '0;
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      sk_data[0]   <= '0;
      sk_data[1]   <= '0;
      sk_last[0]   <= 1'b0;
      sk_last[1]   <= 1'b0;
      sk_wp        <= 1'b0;
      sk_rp        <= 1'b0;
      sk_cnt       <= '0;
    end else begin
      done <= done_set;
      err  <= (state == S_IDLE) && start && !start_ok;

      if ((state == S_IDLE) && start_ok) begin
        len_q       <= frame_len;
        gap_q       <= gap_cycles;
        nfr_q       <= num_frames;
        each_q      <= cfg_each_frame;
        cfg_q       <= cfg_word;
        frames_sent <= '0;
      end else if (last_hs) begin
        frames_sent <= frames_inc;
      end

      if (state_nxt == S_IDLE)              stop_q <= 1'b0;
      else if ((state != S_IDLE) && stop)   stop_q <= 1'b1;

      if ((state == S_SEND) && last_hs)         gap_cnt <= gap_q;
      else if ((state == S_GAP) && (gap_cnt != '0)) gap_cnt <= gap_cnt - GAP_W'(1);

      if (state_nxt != S_SEND) rd_cnt <= '0;
      else if (rd_en)          rd_cnt <= rd_cnt + ONE;

      rd_pend      <= rd_en;
      rd_pend_last <= rd_en && (rd_cnt == len_q - ONE);

      if (rd_pend) begin
        sk_data[sk_wp] <= rd_data;
        sk_last[sk_wp] <= rd_pend_last;
        sk_wp          <= ~sk_wp;
      end
      if (pop) sk_rp <= ~sk_rp;
      sk_cnt <= sk_cnt + 2'(rd_pend) - 2'(pop);
    end
  end

endmodule
